// File: rtl/vga_pmod_rx_pkg.sv
// Shared types and constants for the TinyVGA PMOD receiver: FSM states,
// PMOD bit positions, counter limits and the CRC-16-CCITT helper.
package vga_pmod_rx_pkg;

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      CONFIRM,
      LOCKED
   } rx_state_e;

   localparam int CNT_W = 11;
   localparam logic [CNT_W-1:0] HCNT_MAX = 11'd2047;

   localparam int PMOD_HSYNC = 7;
   localparam int PMOD_B0    = 6;
   localparam int PMOD_G0    = 5;
   localparam int PMOD_R0    = 4;
   localparam int PMOD_VSYNC = 3;
   localparam int PMOD_B1    = 2;
   localparam int PMOD_G1    = 1;
   localparam int PMOD_R1    = 0;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // MSB-first CRC-16-CCITT update of one byte
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/vga_sync_edge_det.sv
// Sync polarity normalisation and single-cycle assert-edge detection on an
// already-registered sync bit.
module vga_sync_edge_det #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sync_in,
   output logic assert_pulse
);

   logic prev_q, prev_d;
   logic cur_active, prev_active;

   // Reset value 0 reads as "asserted" for active-low sync, so no edge fires out of reset
   always_comb begin
      prev_d       = sync_in;
      cur_active   = sync_in ^ ACTIVE_LOW;
      prev_active  = prev_q ^ ACTIVE_LOW;
      assert_pulse = cur_active & ~prev_active;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_q <= 1'b0;
      else       prev_q <= prev_d;
   end

endmodule

// File: rtl/vga_pmod_rx.sv
// TinyVGA PMOD receiver: sync decode, mode lock and pixel/colour recovery.
// Define VGA_PMOD_RX_CRC_EN to enable the per-frame CRC on frame_crc.
module vga_pmod_rx
   import vga_pmod_rx_pkg::*;
#(
   parameter int H_START         = 144,
   parameter int H_ACTIVE        = 640,
   parameter int V_START         = 35,
   parameter int V_ACTIVE        = 480,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  pmod_in,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [5:0]  pix_rgb,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        sync_err,
   output logic [10:0] h_total,
   output logic [10:0] v_total,
   output logic [15:0] frame_crc
);

   localparam logic [CNT_W-1:0] H_LO   = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] H_HI   = CNT_W'(H_START + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_LO   = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] V_HI   = CNT_W'(V_START + V_ACTIVE);
   localparam logic [7:0]       LOCK_N = 8'(LOCK_FRAMES);
   localparam bit               ACT_LOW = (SYNC_ACTIVE_LOW != 0);

   logic [7:0]       in_q, in_d;
   logic             hs_edge, vs_edge;
   logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic             h_seen_q, h_seen_d;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cand_h_q, cand_h_d, cand_v_q, cand_v_d;
   logic             cand_h_vld_q, cand_h_vld_d;
   logic [7:0]       match_cnt_q, match_cnt_d;
   logic [9:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [5:0]       pix_rgb_q, pix_rgb_d;
   logic             pix_valid_q, pix_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             locked_q, locked_d;
   logic             sync_err_q, sync_err_d;
   logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
   logic [11:0]      line_len, frame_len;
   logic             line_done, line_bad, timeout, lock_lost;
   logic             in_h, in_v;

   vga_sync_edge_det #(.ACTIVE_LOW(ACT_LOW)) u_hs_edge (
      .clk          (clk),
      .reset        (reset),
      .sync_in      (in_q[PMOD_HSYNC]),
      .assert_pulse (hs_edge)
   );

   vga_sync_edge_det #(.ACTIVE_LOW(ACT_LOW)) u_vs_edge (
      .clk          (clk),
      .reset        (reset),
      .sync_in      (in_q[PMOD_VSYNC]),
      .assert_pulse (vs_edge)
   );

   // Periods are 12 bits wide so a saturated counter never aliases a real period
   always_comb begin
      in_d      = pmod_in;
      line_len  = {1'b0, hcnt_q} + 12'd1;
      frame_len = {1'b0, vcnt_q} + 12'd1;

      if (hs_edge)                 hcnt_d = '0;
      else if (hcnt_q == HCNT_MAX) hcnt_d = HCNT_MAX;
      else                         hcnt_d = hcnt_q + 11'd1;

      if (vs_edge)                            vcnt_d = '0;
      else if (hs_edge && vcnt_q != HCNT_MAX) vcnt_d = vcnt_q + 11'd1;
      else                                    vcnt_d = vcnt_q;

      h_seen_d  = h_seen_q | hs_edge;
      line_done = hs_edge & h_seen_q;
      line_bad  = line_done && cand_h_vld_q && (line_len != {1'b0, cand_h_q});
      timeout   = (hcnt_d == HCNT_MAX);
   end

   always_comb begin
      state_d       = state_q;
      cand_h_d      = cand_h_q;
      cand_h_vld_d  = cand_h_vld_q;
      cand_v_d      = cand_v_q;
      match_cnt_d   = match_cnt_q;
      h_total_d     = h_total_q;
      v_total_d     = v_total_q;
      locked_d      = locked_q;
      sync_err_d    = 1'b0;

      if (state_q == MEASURE && line_done && !cand_h_vld_q && !line_len[11]) begin
         cand_h_d     = line_len[10:0];
         cand_h_vld_d = 1'b1;
      end

      unique case (state_q)
         SEARCH: begin
            if (vs_edge) state_d = MEASURE;
         end
         MEASURE: begin
            // A frame without any measured line cannot be confirmed; keep measuring
            if (vs_edge && cand_h_vld_d) begin
               cand_v_d    = frame_len[10:0];
               h_total_d   = cand_h_d;
               v_total_d   = frame_len[10:0];
               match_cnt_d = '0;
               state_d     = CONFIRM;
            end
         end
         CONFIRM: begin
            if (vs_edge) begin
               if (frame_len == {1'b0, cand_v_q}) begin
                  match_cnt_d = match_cnt_q + 8'd1;
                  if (match_cnt_d == LOCK_N) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  state_d      = MEASURE;
                  cand_h_vld_d = 1'b0;
               end
            end
         end
         LOCKED: begin
         end
      endcase

      lock_lost = (state_q != SEARCH) &&
                  (line_bad || timeout ||
                   (state_q == LOCKED && vs_edge && frame_len != {1'b0, v_total_q}));
      if (lock_lost) begin
         state_d      = SEARCH;
         locked_d     = 1'b0;
         sync_err_d   = 1'b1;
         cand_h_vld_d = 1'b0;
      end

      frame_start_d = vs_edge && (state_d == LOCKED);
   end

   // Coordinates come from the next counter values so they line up with in_q colour
   always_comb begin
      in_h        = (hcnt_d >= H_LO) && (hcnt_d < H_HI);
      in_v        = (vcnt_d >= V_LO) && (vcnt_d < V_HI);
      pix_valid_d = (state_d == LOCKED) && in_h && in_v;
      pix_x_d     = '0;
      pix_y_d     = '0;
      pix_rgb_d   = '0;
      if (pix_valid_d) begin
         pix_x_d   = 10'(hcnt_d - H_LO);
         pix_y_d   = 10'(vcnt_d - V_LO);
         pix_rgb_d = {in_q[PMOD_R1], in_q[PMOD_R0], in_q[PMOD_G1],
                      in_q[PMOD_G0], in_q[PMOD_B1], in_q[PMOD_B0]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q          <= '0;
         hcnt_q        <= HCNT_MAX;
         vcnt_q        <= '0;
         h_seen_q      <= 1'b0;
         state_q       <= SEARCH;
         cand_h_q      <= '0;
         cand_h_vld_q  <= 1'b0;
         cand_v_q      <= '0;
         match_cnt_q   <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_rgb_q     <= '0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         sync_err_q    <= 1'b0;
         h_total_q     <= '0;
         v_total_q     <= '0;
      end else begin
         in_q          <= in_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         h_seen_q      <= h_seen_d;
         state_q       <= state_d;
         cand_h_q      <= cand_h_d;
         cand_h_vld_q  <= cand_h_vld_d;
         cand_v_q      <= cand_v_d;
         match_cnt_q   <= match_cnt_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_rgb_q     <= pix_rgb_d;
         pix_valid_q   <= pix_valid_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         sync_err_q    <= sync_err_d;
         h_total_q     <= h_total_d;
         v_total_q     <= v_total_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_rgb     = pix_rgb_q;
   assign pix_valid   = pix_valid_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;
   assign h_total     = h_total_q;
   assign v_total     = v_total_q;

`ifdef VGA_PMOD_RX_CRC_EN
   logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d;
   logic        frame_ok_q, frame_ok_d;

   // frame_ok marks a frame that began on a LOCKED vsync edge and stayed locked
   always_comb begin
      crc_acc_d   = crc_acc_q;
      frame_crc_d = frame_crc_q;
      frame_ok_d  = frame_ok_q;
      if (pix_valid_d) crc_acc_d = crc16_byte(crc_acc_q, {2'b00, pix_rgb_d});
      if (frame_start_d) begin
         if (frame_ok_q) frame_crc_d = crc_acc_q;
         crc_acc_d  = CRC_INIT;
         frame_ok_d = 1'b1;
      end
      if (state_d != LOCKED) frame_ok_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_acc_q   <= CRC_INIT;
         frame_crc_q <= '0;
         frame_ok_q  <= 1'b0;
      end else begin
         crc_acc_q   <= crc_acc_d;
         frame_crc_q <= frame_crc_d;
         frame_ok_q  <= frame_ok_d;
      end
   end

   assign frame_crc = frame_crc_q;
`else
   assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_pmod_rx.sv
// Directed bench for vga_pmod_rx using a reduced 40x20 video mode so several
// lock/unlock sequences fit in a short run.
module tb_vga_pmod_rx;

   // Mode: 40 clocks per line, hsync low for h 0..3, active h 8..31;
   // 20 lines per frame, vsync low for lines 0..1, active lines 3..14.
   localparam int LINE_LEN  = 40;
   localparam int FRAME_LEN = 20;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  pmodIn;
   logic [9:0]  pixX, pixY;
   logic [5:0]  pixRgb;
   logic        pixValid, frameStart, lockedOut, syncErr;
   logic [10:0] hTotal, vTotal;
   logic [15:0] frameCrc;

   int checks = 0;
   int errors = 0;
   int syncErrCount = 0;
   int gh, gv;
   int longLine = -1;
   bit constColour = 1'b0;

   vga_pmod_rx #(
      .H_START         (8),
      .H_ACTIVE        (24),
      .V_START         (3),
      .V_ACTIVE        (12),
      .SYNC_ACTIVE_LOW (1),
      .LOCK_FRAMES     (2)
   ) dut (
      .clk         (clock),
      .reset       (reset),
      .pmod_in     (pmodIn),
      .pix_x       (pixX),
      .pix_y       (pixY),
      .pix_rgb     (pixRgb),
      .pix_valid   (pixValid),
      .frame_start (frameStart),
      .locked      (lockedOut),
      .sync_err    (syncErr),
      .h_total     (hTotal),
      .v_total     (vTotal),
      .frame_crc   (frameCrc)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (!reset && syncErr) syncErrCount++;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] genPmod(input int h, input int v, input bit constCol);
      logic [5:0] rgb;
      logic hs, vs;
      hs  = (h < 4) ? 1'b0 : 1'b1;
      vs  = (v < 2) ? 1'b0 : 1'b1;
      rgb = 6'd0;
      if (h >= 8 && h < 32 && v >= 3 && v < 15)
         rgb = constCol ? 6'h3F : 6'((((h - 8) * 7) + ((v - 3) * 3) + 5) & 63);
      return {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
   endfunction

   task automatic advanceGen();
      int len;
      len = (gv == longLine) ? LINE_LEN + 1 : LINE_LEN;
      gh++;
      if (gh >= len) begin
         gh = 0;
         if (gv == longLine) longLine = -1;
         gv = (gv == FRAME_LEN - 1) ? 0 : gv + 1;
      end
   endtask

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         pmodIn = genPmod(gh, gv, constColour);
         advanceGen();
         @(negedge clock);
      end
   endtask

   task automatic applyIdle(input int n);
      for (int i = 0; i < n; i++) begin
         pmodIn = 8'h88;
         @(negedge clock);
      end
   endtask

   task automatic runTo(input int h, input int v);
      int guard;
      guard = 0;
      while (!(gh == h && gv == v) && guard < 2000) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput("runTo_reached", 32'(gh == h && gv == v), 32'd1);
   endtask

   // Entry: next sample to drive is (0,0) of a frame and the receiver is searching
   task automatic acquireLock(input string tag);
      applyStimulus(3 * LINE_LEN * FRAME_LEN);
      applyStimulus(1);
      checkOutput({tag, "_prelock"}, 32'(lockedOut), 32'd0);
      applyStimulus(1);
      checkOutput({tag, "_locked"}, 32'(lockedOut), 32'd1);
      checkOutput({tag, "_fstart"}, 32'(frameStart), 32'd1);
      checkOutput({tag, "_htotal"}, 32'(hTotal), 32'd40);
      checkOutput({tag, "_vtotal"}, 32'(vTotal), 32'd20);
   endtask

`ifdef VGA_PMOD_RX_CRC_EN
   function automatic logic [15:0] crcModel(input int nBytes, input logic [7:0] b);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      for (int n = 0; n < nBytes; n++) begin
         for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction
`endif

   initial begin
      reset  = 1'b1;
      pmodIn = 8'h88;
      gh     = 0;
      gv     = 10;
      repeat (3) @(negedge clock);
      checkOutput("rst_locked", 32'(lockedOut), 32'd0);
      checkOutput("rst_valid", 32'(pixValid), 32'd0);
      checkOutput("rst_htotal", 32'(hTotal), 32'd0);
      checkOutput("rst_vtotal", 32'(vTotal), 32'd0);
      checkOutput("rst_syncerr", 32'(syncErr), 32'd0);
      checkOutput("rst_crc", 32'(frameCrc), 32'd0);
      reset = 1'b0;

      runTo(0, 0);
      acquireLock("lock1");
      checkOutput("lock1_no_syncerr", 32'(syncErrCount), 32'd0);

      // Pixel recovery at the active-area corners
      runTo(7, 3);
      applyStimulus(2);
      checkOutput("pre_x0_valid", 32'(pixValid), 32'd0);
      applyStimulus(1);
      checkOutput("p00_valid", 32'(pixValid), 32'd1);
      checkOutput("p00_x", 32'(pixX), 32'd0);
      checkOutput("p00_y", 32'(pixY), 32'd0);
      checkOutput("p00_rgb", 32'(pixRgb), 32'd5);
      runTo(13, 5);
      applyStimulus(2);
      checkOutput("p52_x", 32'(pixX), 32'd5);
      checkOutput("p52_y", 32'(pixY), 32'd2);
      checkOutput("p52_rgb", 32'(pixRgb), 32'd46);
      runTo(31, 14);
      applyStimulus(2);
      checkOutput("plast_valid", 32'(pixValid), 32'd1);
      checkOutput("plast_x", 32'(pixX), 32'd23);
      checkOutput("plast_y", 32'(pixY), 32'd11);
      checkOutput("plast_rgb", 32'(pixRgb), 32'd7);
      applyStimulus(1);
      checkOutput("after_last_valid", 32'(pixValid), 32'd0);
      checkOutput("after_last_x", 32'(pixX), 32'd0);
      checkOutput("after_last_rgb", 32'(pixRgb), 32'd0);
      runTo(8, 15);
      applyStimulus(2);
      checkOutput("below_valid", 32'(pixValid), 32'd0);

      // One constant-colour frame, reported on the following frame_start
      runTo(0, 0);
      applyStimulus(1);
      constColour = 1'b1;
      runTo(0, 0);
      constColour = 1'b0;
      applyStimulus(2);
      checkOutput("crc_fstart", 32'(frameStart), 32'd1);
`ifdef VGA_PMOD_RX_CRC_EN
      checkOutput("crc_value", 32'(frameCrc), 32'(crcModel(288, 8'h3F)));
`else
      checkOutput("crc_value", 32'(frameCrc), 32'd0);
`endif
      applyStimulus(1);
      checkOutput("fstart_single", 32'(frameStart), 32'd0);

      // Line 5 stretched to 41 clocks: loss detected at the line-6 hsync edge
      longLine = 5;
      runTo(0, 6);
      applyStimulus(2);
      checkOutput("long_syncerr", 32'(syncErr), 32'd1);
      checkOutput("long_locked", 32'(lockedOut), 32'd0);
      applyStimulus(1);
      checkOutput("long_syncerr_pulse", 32'(syncErr), 32'd0);
      checkOutput("long_htotal_hold", 32'(hTotal), 32'd40);
      runTo(0, 0);
      acquireLock("relock_line");

      // hsync stopped after the (0,5) edge; hcnt=19 at (19,5), saturates on idle sample 2028
      runTo(20, 5);
      applyIdle(2028);
      checkOutput("to_before_locked", 32'(lockedOut), 32'd1);
      checkOutput("to_before_syncerr", 32'(syncErr), 32'd0);
      applyIdle(1);
      checkOutput("to_syncerr", 32'(syncErr), 32'd1);
      checkOutput("to_locked", 32'(lockedOut), 32'd0);
      applyIdle(71);
      checkOutput("to_vtotal_hold", 32'(vTotal), 32'd20);
      runTo(0, 0);
      acquireLock("relock_timeout");

      // Asynchronous reset in the middle of an active line
      runTo(15, 6);
      checkOutput("mid_valid", 32'(pixValid), 32'd1);
      checkOutput("mid_x", 32'(pixX), 32'd5);
      checkOutput("mid_y", 32'(pixY), 32'd3);
      reset = 1'b1;
      #1;
      checkOutput("arst_locked", 32'(lockedOut), 32'd0);
      checkOutput("arst_valid", 32'(pixValid), 32'd0);
      checkOutput("arst_x", 32'(pixX), 32'd0);
      checkOutput("arst_htotal", 32'(hTotal), 32'd0);
      checkOutput("arst_vtotal", 32'(vTotal), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      runTo(0, 0);
      acquireLock("relock_reset");

      checkOutput("syncerr_total", 32'(syncErrCount), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
